// File: rtl/miner_job_ctrl.sv
// miner_job_ctrl: job sequencer for the multi-core SHA-256 miner.
// Counts midstate and header-remainder words as they arrive, then sweeps the
// nonce space NUM_CORES nonces per cycle. It latches simultaneous core claims
// and presents them one at a time, lowest core first, until the host responds.
//
// Ports:
//   clk, n_rst          clock, asynchronous active-low reset
//   start_found         new-job marker; overrides everything
//   word_valid          one payload word present this cycle
//   core_claim          per-core candidate flags (SOLVE only)
//   sol_resp_valid      host response strobe
//   sol_resp            01 continue, 10 accept, 11 abort, 00 ignored
//   mid_shift_en        shift word into the midstate register
//   rem_shift_en        shift word into the header-remainder register
//   core_run            cores evaluate nonce_base+i this cycle
//   nonce_base          current sweep base (multiple of NUM_CORES)
//   claim_valid         claim presented to the host
//   claim_core          core index of the presented claim
//   claim_nonce         nonce of the presented claim
//   exhausted           sweep ended with no accepted solution
//   state               IDLE=0 LOAD_MID=1 LOAD_REM=2 SOLVE=3 HALT=4 DONE=5
//   *_state             one-hot decodes of state
module miner_job_ctrl #(
    parameter int unsigned MID_WORDS = 8,
    parameter int unsigned REM_WORDS = 3,
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned NONCE_W   = 32,
    localparam int unsigned CoreW    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start_found,
    input  logic                 word_valid,
    input  logic [NUM_CORES-1:0] core_claim,
    input  logic                 sol_resp_valid,
    input  logic [1:0]           sol_resp,
    output logic                 mid_shift_en,
    output logic                 rem_shift_en,
    output logic                 core_run,
    output logic [NONCE_W-1:0]   nonce_base,
    output logic                 claim_valid,
    output logic [CoreW-1:0]     claim_core,
    output logic [NONCE_W-1:0]   claim_nonce,
    output logic                 exhausted,
    output logic [2:0]           state,
    output logic                 idle_state,
    output logic                 mid_state,
    output logic                 head_state,
    output logic                 solve_state,
    output logic                 halt_state
);

    localparam int unsigned MaxWords = (MID_WORDS > REM_WORDS) ? MID_WORDS : REM_WORDS;
    localparam int unsigned CntW     = $clog2(MaxWords + 1);
    // 2^NONCE_W - NUM_CORES, valid because NUM_CORES is a power of two.
    localparam logic [NONCE_W-1:0] LastBase = ~NONCE_W'(NUM_CORES - 1);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StLoadMid = 3'd1,
        StLoadRem = 3'd2,
        StSolve   = 3'd3,
        StHalt    = 3'd4,
        StDone    = 3'd5
    } state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [NONCE_W-1:0]   base_q, base_d;
    logic [NUM_CORES-1:0] pend_q, pend_d;
    logic                 exh_q, exh_d;

    logic [CoreW-1:0]     claim_idx;
    logic [NUM_CORES-1:0] pend_after;
    logic                 last_base;

    // Lowest set pending bit wins.
    always_comb begin
        claim_idx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (pend_q[i]) claim_idx = CoreW'(i);
        end
    end

    assign pend_after = pend_q & ~(NUM_CORES'(1) << claim_idx);
    assign last_base  = (base_q == LastBase);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        pend_d  = pend_q;
        exh_d   = exh_q;

        if (start_found) begin
            state_d = StLoadMid;
            cnt_d   = '0;
            base_d  = '0;
            pend_d  = '0;
            exh_d   = 1'b0;
        end else begin
            case (state_q)
                StLoadMid: begin
                    if (word_valid) begin
                        if (cnt_q == CntW'(MID_WORDS - 1)) begin
                            state_d = StLoadRem;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                StLoadRem: begin
                    if (word_valid) begin
                        if (cnt_q == CntW'(REM_WORDS - 1)) begin
                            state_d = StSolve;
                            cnt_d   = '0;
                            base_d  = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                StSolve: begin
                    if (|core_claim) begin
                        pend_d  = core_claim;
                        state_d = StHalt;
                    end else if (last_base) begin
                        state_d = StDone;
                        exh_d   = 1'b1;
                    end else begin
                        base_d = base_q + NONCE_W'(NUM_CORES);
                    end
                end
                StHalt: begin
                    if (sol_resp_valid) begin
                        case (sol_resp)
                            2'b01: begin
                                pend_d = pend_after;
                                if (pend_after == '0) begin
                                    // Last claim of this base rejected: resume the sweep.
                                    if (last_base) begin
                                        state_d = StDone;
                                        exh_d   = 1'b1;
                                    end else begin
                                        state_d = StSolve;
                                        base_d  = base_q + NONCE_W'(NUM_CORES);
                                    end
                                end
                            end
                            2'b10, 2'b11: begin
                                pend_d  = '0;
                                state_d = StIdle;
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            base_q  <= '0;
            pend_q  <= '0;
            exh_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            pend_q  <= pend_d;
            exh_q   <= exh_d;
        end
    end

    assign mid_shift_en = (state_q == StLoadMid) && word_valid && !start_found;
    assign rem_shift_en = (state_q == StLoadRem) && word_valid && !start_found;
    assign core_run     = (state_q == StSolve);
    assign nonce_base   = base_q;
    assign claim_valid  = (state_q == StHalt);
    assign claim_core   = claim_idx;
    assign claim_nonce  = base_q + NONCE_W'(claim_idx);
    assign exhausted    = exh_q;
    assign state        = state_q;
    assign idle_state   = (state_q == StIdle);
    assign mid_state    = (state_q == StLoadMid);
    assign head_state   = (state_q == StLoadRem);
    assign solve_state  = (state_q == StSolve);
    assign halt_state   = (state_q == StHalt);

endmodule

// File: doc/miner_job_ctrl.md
# miner_job_ctrl

Parametrised job-sequencing controller for the multi-core SHA-256 miner. It counts midstate and header-remainder words as they are shifted in, then sweeps the 32-bit nonce space across `NUM_CORES` parallel hash cores. Simultaneous solution claims are arbitrated and queued, and each claim is held until the host responds. It sits between the serial receive path, the core array and the host-response logic, and replaces the fixed single-core controller that relied on externally generated shift-done flags.

## Interface
- `MID_WORDS`, default 8: number of 32-bit midstate words per job.
- `REM_WORDS`, default 3: number of 32-bit header-remainder words per job.
- `NUM_CORES`, default 4: number of parallel cores. Must be a power of two, 1..16.
- `NONCE_W`, default 32: nonce width.
- `clk`  in  1  clock.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `start_found`  in  1  new-job marker. Highest priority in every state.
- `word_valid`  in  1  one payload word is present on the serial path this cycle.
- `core_claim`  in  NUM_CORES  bit i means core i found a candidate for `nonce_base+i` this cycle.
- `sol_resp_valid`  in  1  host response strobe.
- `sol_resp`  in  2  response code: 01 = false positive/continue; 10 = accepted; 11 = abort; 00 = ignored.
- `mid_shift_en`  out  1  shift word into the midstate register.
- `rem_shift_en`  out  1  shift word into the header-remainder register.
- `core_run`  out  1  cores evaluate `nonce_base+i` this cycle.
- `nonce_base`  out  NONCE_W  current sweep base. Always a multiple of NUM_CORES.
- `claim_valid`  out  1  a claim is presented to the host.
- `claim_core`  out  max(1,$clog2(NUM_CORES))  index of the presented claim.
- `claim_nonce`  out  NONCE_W  nonce of the presented claim.
- `exhausted`  out  1  sweep ended with no accepted solution.
- `state`  out  3  encoding: IDLE=0, LOAD_MID=1, LOAD_REM=2, SOLVE=3, HALT=4, DONE=5.
- `idle_state`, `mid_state`, `head_state`, `solve_state`, `halt_state`  out  1 each  one-hot decodes of `state`.

## Operation
- **Reset.** All registers clear: state IDLE, word counter 0, `nonce_base` 0, pending mask 0, `claim_core` 0, `claim_nonce` 0, `exhausted` 0.
- **`start_found` priority.** From any state, `start_found`=1 sets next state LOAD_MID and clears the word counter, `nonce_base`, pending mask and `exhausted`. A `word_valid` in the same cycle is not counted and not shifted. This includes reset-free abandonment of a job mid-load, mid-sweep or mid-HALT.
- **IDLE.** Waits for `start_found`.
- **LOAD_MID.**
  - `mid_shift_en` = `word_valid`; each accepted word increments the counter.
  - The word that brings the count to `MID_WORDS` moves to LOAD_REM and clears the counter.
- **LOAD_REM.**
  - `rem_shift_en` = `word_valid`.
  - The `REM_WORDS`-th word moves to SOLVE with `nonce_base`=0.
- **SOLVE.** `core_run`=1.
  - **No claim:** `nonce_base` += NUM_CORES.
  - **Last base, no claim:** if `nonce_base` == 2^NONCE_W − NUM_CORES and there is no claim, go to DONE with `exhausted`=1 instead of wrapping.
  - **Any claim bit set:** `nonce_base` holds; latch `core_claim` into the pending mask; go to HALT.
- **HALT.** `claim_valid`=1; `claim_core` is the lowest set pending bit; `claim_nonce` = `nonce_base` + `claim_core`. Both are combinational from registers.
  - **01:** clear that pending bit. If other bits remain, stay in HALT presenting the next index. If none remain, return to SOLVE with `nonce_base` += NUM_CORES; if that base was the last base, go to DONE with `exhausted`=1.
  - **10 or 11:** clear the pending mask and go to IDLE.
  - **00, or `sol_resp_valid`=0:** hold.
- **DONE.** `exhausted` stays 1 until `start_found` is seen. `core_run`=0.
- `core_claim` is ignored outside SOLVE. `word_valid` is ignored outside the LOAD states.
- `idle_state` is 1 in IDLE only. DONE has no separate decode; use `exhausted`.

## Timing
- State, counter, `nonce_base` and pending mask are registered.
- All outputs are combinational decodes of registers plus the same-cycle `word_valid`/`start_found`. `mid_shift_en` and `rem_shift_en` are gated by `!start_found`.
- **Load length:** with back-to-back `word_valid` after `start_found`, SOLVE is entered after exactly MID_WORDS+REM_WORDS cycles (11 cycles at defaults).
- **Claim to host:** a claim in SOLVE cycle t gives `claim_valid`=1 in cycle t+1.
- **Response to resume:** a response in cycle t takes effect at cycle t+1.
- Throughput in SOLVE is NUM_CORES nonces per cycle.
- Arithmetic wraps modulo 2^NONCE_W but is never reached, because the last-base check precedes the add.

## Test plan
- **Job load:** reset, `start_found`, then 11 consecutive `word_valid`.
  - Expect 8 `mid_shift_en`, then 3 `rem_shift_en`.
  - `solve_state` rises on the cycle after the 11th word, with `nonce_base`=0.
- **Dual claim:** NUM_CORES=4, `core_claim`=4'b1010 at `nonce_base`=0x40.
  - Expect HALT presenting core 1 / nonce 0x41.
  - `sol_resp`=01 then presents core 3 / 0x43.
  - A second 01 returns to SOLVE with `nonce_base`=0x44.
- **Accept:** claim at 0x100 followed by `sol_resp`=10 → IDLE next cycle, `claim_valid`=0.
- **Exhaustion:** NONCE_W=8, NUM_CORES=4, no claims → `nonce_base` reaches 0xFC, then DONE with `exhausted`=1 and no wrap to 0.
- **Restart mid-operation:** `start_found` pulses mid-LOAD_REM (word 2 of 3) and again mid-HALT.
  - Each time: LOAD_MID next cycle, counter 0, pending mask 0.
  - A coincident `word_valid` is not shifted.
- **Async reset:** assert `n_rst` mid-SOLVE → all outputs return to their reset values immediately, without waiting for a clock edge.
